// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Debug view of both state machines.
  typedef struct packed {
    loader_state_e fsm;
    rx_state_e     rx;
  } loader_dbg_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid or frame_err pulse per frame.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output rx_state_e  state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Edge-triggered so a low line after a framing error is not re-taken.
        if (prev_q && !sync_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = shift_q;
  assign frame_err_o  = ferr_q;
  assign state_o      = state_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over
// UART and writes it into program memory while holding the CPU in reset.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          MEMORY_DEPTH = 512,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
  parameter int          DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  start_load,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           word_count,
  output loader_dbg_t           dbg
);

  localparam int WIDX_W = $clog2(MEMORY_DEPTH);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;
  rx_state_e  rx_state;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clk_i        (clk),
    .rst_ni       (reset),
    .rx_i         (rx),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_byte),
    .frame_err_o  (rx_ferr),
    .state_o      (rx_state)
  );

  loader_state_e         state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [WIDX_W-1:0]     word_idx_q, word_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_reset_n_q, cpu_reset_n_d;
  logic [15:0]           word_count_q, word_count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= HDR_LO;
      n_q           <= '0;
      byte_idx_q    <= '0;
      word_idx_q    <= '0;
      word_q        <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      mem_wdata_q   <= '0;
      cpu_reset_n_q <= 1'b0;
      word_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      byte_idx_q    <= byte_idx_d;
      word_idx_q    <= word_idx_d;
      word_q        <= word_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      word_count_q  <= word_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    byte_idx_d    = byte_idx_q;
    word_idx_d    = word_idx_q;
    word_d        = word_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_reset_n_d = (state_q == DONE);
    word_count_d  = word_count_q;
    // start_load outranks any byte or error arriving in the same cycle.
    if (start_load) begin
      state_d       = HDR_LO;
      byte_idx_d    = '0;
      word_count_d  = '0;
      cpu_reset_n_d = 1'b0;
    end else if (rx_ferr && (state_q inside {HDR_LO, HDR_HI, DATA})) begin
      state_d = ERROR;
    end else if (rx_valid) begin
      case (state_q)
        HDR_LO: begin
          n_d     = {8'h00, rx_byte};
          state_d = HDR_HI;
        end
        HDR_HI: begin
          n_d = {rx_byte, n_q[7:0]};
          if (n_d == 16'd0) begin
            state_d = DONE;
          end else if (n_d > 16'(MEMORY_DEPTH)) begin
            state_d = ERROR;
          end else begin
            state_d      = DATA;
            byte_idx_d   = '0;
            word_idx_d   = '0;
            word_count_d = '0;
          end
        end
        DATA: begin
          word_d     = {rx_byte, word_q[DATA_WIDTH-1:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
            mem_we_d     = 1'b1;
            mem_wdata_d  = word_d;
            mem_addr_d   = BASE_ADDR + {{(30 - WIDX_W){1'b0}}, word_idx_q, 2'b00};
            word_idx_d   = word_idx_q + 1'b1;
            word_count_d = word_count_q + 16'd1;
            if (word_count_q + 16'd1 == n_q) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign load_done   = (state_q == DONE);
  assign load_error  = (state_q == ERROR);
  assign word_count  = word_count_q;
  assign dbg         = '{fsm: state_q, rx: rx_state};

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serial image stimulus, write scoreboard
// against an image-level reference model.
module tb_uart_program_loader;
  import loader_pkg::*;

  localparam int          CPB   = 8;
  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        start_load = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;
  logic [15:0] word_count;
  loader_dbg_t dbg;

  uart_program_loader #(
    .CLKS_PER_BIT (CPB),
    .MEMORY_DEPTH (DEPTH),
    .BASE_ADDR    (BASE),
    .DATA_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .start_load  (start_load),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .load_done   (load_done),
    .load_error  (load_error),
    .word_count  (word_count),
    .dbg         (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          wr_cnt = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  img[$];
  logic        prev_we = 1'b0;
  logic        done_prev = 1'b0;
  logic        chk_rstn = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: every write must match the head of the expected queue
  logic [63:0] sb_e;
  always @(negedge clk) begin
    if (mem_we) begin
      check_eq("we_gap", prev_we, 0);
      wr_cnt++;
      if (exp_q.size() > 0) begin
        sb_e = exp_q.pop_front();
        check_eq("wr_addr", mem_addr, sb_e[63:32]);
        check_eq("wr_data", mem_wdata, sb_e[31:0]);
      end else begin
        check_eq("wr_expected", 64'(exp_q.size()), 1);
      end
    end
    if (load_done && !done_prev) begin
      check_eq("rstn_at_done_entry", cpu_reset_n, 0);
      chk_rstn = 1'b1;
    end else if (chk_rstn) begin
      chk_rstn = 1'b0;
      if (load_done) check_eq("rstn_release", cpu_reset_n, 1);
    end
    prev_we   = mem_we;
    done_prev = load_done;
  end

  // driver tasks (all entered #1 after a rising edge)
  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
  endtask

  task automatic idle_bits(input int bits);
    repeat (bits * CPB) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_load = 1'b1;
    @(posedge clk);
    #1;
    start_load = 1'b0;
  endtask

  task automatic make_image(input int n);
    int words;
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    words = (n <= DEPTH) ? n : 1;
    for (int i = 0; i < words * 4; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  // reference model: decode the image from the protocol rules, then send it
  task automatic run_image(input string tag);
    int   n;
    int   nw;
    int   base_cnt;
    logic exp_done;
    logic exp_err;
    n = {img[1], img[0]};
    nw = 0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    if (n == 0) exp_done = 1'b1;
    else if (n > DEPTH) exp_err = 1'b1;
    else begin
      exp_done = 1'b1;
      nw = n;
      for (int i = 0; i < n; i++)
        exp_q.push_back({BASE + 32'(4 * i),
                         img[2 + 4 * i + 3], img[2 + 4 * i + 2],
                         img[2 + 4 * i + 1], img[2 + 4 * i]});
    end
    base_cnt = wr_cnt;
    foreach (img[i]) send_byte(img[i], 1'b1);
    idle_bits(2);
    check_eq({tag, "_writes"}, 64'(wr_cnt - base_cnt), 64'(nw));
    check_eq({tag, "_left"}, 64'(exp_q.size()), 0);
    check_eq({tag, "_done"}, load_done, exp_done);
    check_eq({tag, "_error"}, load_error, exp_err);
    check_eq({tag, "_cpu_rstn"}, cpu_reset_n, exp_done);
    check_eq({tag, "_word_count"}, word_count, 64'(nw));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_we"}, mem_we, 0);
    check_eq({tag, "_addr"}, mem_addr, BASE);
    check_eq({tag, "_wdata"}, mem_wdata, 0);
    check_eq({tag, "_cpu_rstn"}, cpu_reset_n, 0);
    check_eq({tag, "_done"}, load_done, 0);
    check_eq({tag, "_error"}, load_error, 0);
    check_eq({tag, "_wc"}, word_count, 0);
    check_eq({tag, "_fsm"}, dbg.fsm, HDR_LO);
  endtask

  initial begin
    int   base_cnt;
    int   r;
    int   n;
    logic [7:0] b;

    #23;
    check_reset_values("por");
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_bits(1);

    // reset in the middle of the second header byte
    send_byte(8'h07, 1'b1);
    check_eq("hdr_lo_taken", dbg.fsm, HDR_HI);
    rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("mid_rst");
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_bits(2);
    make_image(2);
    run_image("post_rst");

    // reference program image
    pulse_start();
    check_eq("start_fsm", dbg.fsm, HDR_LO);
    check_eq("start_done", load_done, 0);
    check_eq("start_rstn", cpu_reset_n, 0);
    check_eq("start_wc", word_count, 0);
    img = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h0A, 8'h00, 8'h09, 8'h20};
    run_image("normal");

    pulse_start();
    img = '{8'h00, 8'h00};
    run_image("n0");

    pulse_start();
    make_image(513);
    run_image("n513");

    // N = MEMORY_DEPTH is accepted
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    check_eq("n512_fsm", dbg.fsm, DATA);
    check_eq("n512_error", load_error, 0);

    // framing error on the third data byte
    pulse_start();
    base_cnt = wr_cnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle_bits(2);
    check_eq("ferr_error", load_error, 1);
    check_eq("ferr_fsm", dbg.fsm, ERROR);
    check_eq("ferr_writes", 64'(wr_cnt - base_cnt), 0);
    check_eq("ferr_rstn", cpu_reset_n, 0);
    send_byte(8'h44, 1'b1);
    check_eq("ferr_sticky", load_error, 1);
    pulse_start();
    make_image(2);
    run_image("after_ferr");

    // abort after two data bytes
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    pulse_start();
    check_eq("abort_fsm", dbg.fsm, HDR_LO);
    check_eq("abort_wc", word_count, 0);
    make_image(1);
    run_image("abort");

    // short low glitch is not a start bit
    pulse_start();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    idle_bits(12);
    check_eq("glitch_fsm", dbg.fsm, HDR_LO);
    check_eq("glitch_rx_idle", dbg.rx, RX_IDLE);
    make_image(1);
    run_image("after_glitch");

    // randomized images
    for (int k = 0; k < 6; k++) begin
      pulse_start();
      r = $urandom_range(0, 9);
      if (r == 0) n = 0;
      else if (r == 1) n = $urandom_range(DEPTH + 1, 65535);
      else n = $urandom_range(1, 5);
      make_image(n);
      run_image($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Boot-time upstream stage for the MIPS single-cycle processor.
- Receives a program over a UART serial line, assembles 32-bit instruction words and writes them through the write port of the instruction (program) memory.
- Holds the processor in reset while loading and releases it once the image is complete.
- Contains one UART receiver sub-module and a loader FSM.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4.
- MEMORY_DEPTH, 512, program memory depth in 32-bit words; largest accepted word count.
- BASE_ADDR, 32'h0040_0000, byte address of the first instruction word.
- DATA_WIDTH, 32, instruction word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- start_load  in  1  one-cycle pulse; aborts any load and restarts at header.
- mem_we  out  1  program memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the word being written.
- mem_wdata  out  DATA_WIDTH  instruction word being written.
- cpu_reset_n  out  1  active-low reset to the processor; low while loading.
- load_done  out  1  high while the image is complete.
- load_error  out  1  high after a framing or length error.
- word_count  out  16  number of words written in the current load.

Behaviour:
- Reset (async, reset=0):
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_reset_n=0, load_done=0, load_error=0, word_count=0.
  - FSM=HDR_LO; uart_rx returns to its idle state.
- uart_rx:
  - rx is passed through a 2-flop synchronizer.
  - Falling edge (start bit) starts a counter. At CLKS_PER_BIT/2 the line is re-sampled; if it is high, the edge is a glitch and the receiver returns to idle.
  - Then 8 data bits, LSB first, each sampled at mid-bit (every CLKS_PER_BIT cycles), followed by the stop bit.
  - Stop=1: byte_valid pulses for one cycle with byte_data.
  - Stop=0: frame_err pulses for one cycle and no byte is delivered.
  - The receiver returns to idle at mid-stop-bit and can detect the next start edge immediately.
- Protocol: header of two bytes giving word count N (16-bit, little-endian), then N words of 4 bytes each, little-endian (first byte = bits 7:0).
- FSM states: HDR_LO, HDR_HI, DATA, DONE, ERROR.
  - HDR_LO: on byte, latch N[7:0] and go to HDR_HI.
  - HDR_HI: on byte, latch N[15:8], then:
    - N=0: go to DONE.
    - N>MEMORY_DEPTH: go to ERROR.
    - Otherwise: go to DATA with byte index 0 and word index 0.
  - DATA: shift bytes into the word register. On the 4th byte (cycle t):
    - At t+1: mem_we=1, mem_wdata=word, mem_addr=BASE_ADDR+4*word index; word_count increments on the same edge.
    - If this was word N, go to DONE at t+1.
  - DONE: load_done=1; cpu_reset_n goes high one cycle after entry (registered). Bytes received in DONE are ignored.
  - ERROR: load_error=1, cpu_reset_n stays 0. Bytes are ignored; only start_load or reset exits.
- frame_err in HDR_LO, HDR_HI or DATA sends the FSM to ERROR; any partial word is discarded and no write is issued.
- start_load (any state):
  - Next cycle: FSM=HDR_LO, cpu_reset_n=0, load_done=0, load_error=0, word_count=0, byte index=0.
  - start_load coincident with byte_valid: start_load wins and the byte is discarded.
- mem_addr and mem_wdata hold their last value outside mem_we pulses. mem_we is never high for two consecutive cycles.
- Word index width is clog2(MEMORY_DEPTH). Address arithmetic is 32-bit unsigned; no wrap-around is possible because N is bounded by MEMORY_DEPTH.

Decomposition:
- Shared package loader_pkg:
  - FSM state encoding (HDR_LO=0, HDR_HI=1, DATA=2, DONE=3, ERROR=4).
  - Header length constant HDR_BYTES=2.
  - BYTES_PER_WORD=4.
- One sub-module: uart_rx (synchronizer, bit timer, shift register, byte_valid/frame_err outputs), parameterised by CLKS_PER_BIT.
- The loader FSM, word assembly and address generation live in uart_program_loader.

Test Plan:
- Reset: assert reset=0 mid-frame, then release -> all outputs at their reset values, cpu_reset_n=0, FSM=HDR_LO; the next byte is taken as header low.
- Normal load: send bytes 02 00, 05 00 08 20, 0A 00 09 20 (CLKS_PER_BIT=8 in sim) -> exactly two writes:
  - mem_we pulse 1: mem_addr=0x00400000, mem_wdata=0x20080005.
  - mem_we pulse 2: mem_addr=0x00400004, mem_wdata=0x2009000A.
  - Then word_count=2, load_done=1, and cpu_reset_n=1 one cycle after DONE.
- Length limits:
  - Header 00 00 -> DONE with no mem_we.
  - Header 01 02 (N=513) -> load_error=1, no mem_we, cpu_reset_n=0.
- Framing: the 3rd data byte is sent with stop bit=0 -> load_error=1, no write for the partial word; a following start_load plus a valid image loads correctly.
- Abort and glitch:
  - start_load pulsed after 2 data bytes -> partial word discarded; a new header with one word writes to 0x00400000.
  - A 2-cycle low glitch on rx -> no byte_valid is produced.
